// File: rtl/wave_former_pkg.sv
// Shared types for the wave_former video pipeline: coordinate type and
// frame generator state encoding.
package wave_former_pkg;

  localparam int COORD_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    GAP
  } gen_state_e;

endpackage

// File: rtl/video_frame_gen_if.sv
// AXI4-Stream video link: tuser marks start-of-frame, tlast marks end-of-line.
interface video_frame_gen_if #(
  parameter int DATA_W = 24
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);

endinterface

// File: rtl/raster_counter.sv
// Raster walker: latches the frame geometry on clear and steps x/y over it,
// flagging the last column and the last line.
module raster_counter
  import wave_former_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   step,
  input  coord_t width,
  input  coord_t height,
  output coord_t x,
  output coord_t y,
  output logic   last_x,
  output logic   last_y
);

  coord_t w_r;
  coord_t h_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_r <= '0;
      h_r <= '0;
      x   <= '0;
      y   <= '0;
    end else if (clear) begin
      w_r <= width;
      h_r <= height;
      x   <= '0;
      y   <= '0;
    end else if (step) begin
      if (last_x) begin
        x <= '0;
        // wrap y after the final pixel so x < w_r and y < h_r always hold
        y <= last_y ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last_x = (x == w_r - 1'b1);
  assign last_y = (y == h_r - 1'b1);

endmodule

// File: rtl/video_frame_gen.sv
// Source-side video frame generator: walks a width x height raster, samples a
// combinational pixel source and registers each pixel onto an AXI4-Stream master.
module video_frame_gen
  import wave_former_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  coord_t            width,
  input  coord_t            height,
  output coord_t            x,
  output coord_t            y,
  output logic              pix_req,
  input  logic [DATA_W-1:0] pix_data,
  video_frame_gen_if.master m,
  output logic              busy,
  output logic              frame_done
);

  localparam coord_t GAP_LOAD = (GAP_CYCLES > 0) ? coord_t'(GAP_CYCLES - 1) : '0;

  gen_state_e state_q;
  gen_state_e state_d;
  coord_t     gap_cnt;
  logic       last_x;
  logic       last_y;
  logic       cap;
  logic       load;
  logic       last_frame_q;

  raster_counter u_raster (
    .clk    (clk),
    .rst    (rst),
    .clear  (load),
    .step   (cap),
    .width  (width),
    .height (height),
    .x      (x),
    .y      (y),
    .last_x (last_x),
    .last_y (last_y)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        state_d = ((width == '0) || (height == '0)) ? IDLE : RUN;
      end
      RUN: begin
        cap = ~m.tvalid | m.tready;
        if (cap && last_x && last_y) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // GAP is held for GAP_LOAD+1 cycles, i.e. exactly GAP_CYCLES
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (state_q == RUN && state_d == GAP) begin
      gap_cnt <= GAP_LOAD;
    end else if (state_q == GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m.tdata      <= '0;
      m.tuser      <= 1'b0;
      m.tlast      <= 1'b0;
      m.tvalid     <= 1'b0;
      last_frame_q <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= m.tvalid & m.tready & last_frame_q;
      if (cap) begin
        m.tdata      <= pix_data;
        m.tuser      <= (x == '0) && (y == '0);
        m.tlast      <= last_x;
        m.tvalid     <= 1'b1;
        last_frame_q <= last_x & last_y;
      end else if (m.tready && m.tvalid) begin
        m.tvalid <= 1'b0;
      end
    end
  end

  assign pix_req = cap;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_video_frame_gen.sv
// Scoreboard bench for video_frame_gen: expected beats are queued from a raster
// model and compared as the stream hands them off.
module tb_video_frame_gen;
  import wave_former_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   enable = 1'b0;
  logic   enable5 = 1'b0;
  coord_t width = 16'd4;
  coord_t height = 16'd2;
  logic   rdy = 1'b1;
  logic   rand_rdy = 1'b0;

  coord_t x0, y0, x5, y5;
  logic   pix_req0, pix_req5, busy0, busy5, fd0, fd5;
  logic [23:0] pix_data0, pix_data5;

  video_frame_gen_if #(.DATA_W(24)) s0 ();
  video_frame_gen_if #(.DATA_W(24)) s5 ();

  assign s0.tready = rdy;
  assign s5.tready = 1'b1;
  assign pix_data0 = {y0[11:0], x0[11:0]};
  assign pix_data5 = {y5[11:0], x5[11:0]};

  video_frame_gen #(.DATA_W(24), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .width(width), .height(height),
    .x(x0), .y(y0), .pix_req(pix_req0), .pix_data(pix_data0), .m(s0),
    .busy(busy0), .frame_done(fd0)
  );

  video_frame_gen #(.DATA_W(24), .GAP_CYCLES(5)) dut5 (
    .clk(clk), .rst(rst), .enable(enable5), .width(width), .height(height),
    .x(x5), .y(y5), .pix_req(pix_req5), .pix_data(pix_data5), .m(s5),
    .busy(busy5), .frame_done(fd5)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int beats = 0;
  int tuser_cnt = 0;

  logic [26:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        fd_exp = 1'b0;
  logic        hold_chk = 1'b0;
  logic [26:0] hold_val = '0;
  logic        chk_bubble = 1'b0;
  logic        last_fr_valid = 1'b0;
  int          last_fr_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input int w, input int h);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        logic [11:0] xs;
        logic [11:0] ys;
        xs = 12'(xx);
        ys = 12'(yy);
        exp_q.push_back({(xx == w - 1) && (yy == h - 1), (xx == 0) && (yy == 0),
                         (xx == w - 1), ys, xs});
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tvalid"}, 32'(s0.tvalid), 0);
    chk({tag, "_tuser"},  32'(s0.tuser), 0);
    chk({tag, "_tlast"},  32'(s0.tlast), 0);
    chk({tag, "_tdata"},  32'(s0.tdata), 0);
    chk({tag, "_pix_req"}, 32'(pix_req0), 0);
    chk({tag, "_busy"},   32'(busy0), 0);
    chk({tag, "_fd"},     32'(fd0), 0);
    chk({tag, "_xy"},     {x0, y0}, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy0 || s0.tvalid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_complete"}, 32'(exp_q.size() == 0 && !busy0 && !s0.tvalid), 1);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    else          rdy = 1'b1;
  end

  // stream monitor: scoreboard pop, stall stability and frame_done timing
  always @(negedge clk) begin
    logic [26:0] e;
    if (mon_en) begin
      chk("frame_done", 32'(fd0), 32'(fd_exp));
      if (hold_chk)
        chk("stall_hold", {5'd0, s0.tvalid, s0.tuser, s0.tlast, s0.tdata}, {5'd0, hold_val});
      hold_chk = s0.tvalid && !s0.tready;
      hold_val = {s0.tvalid, s0.tuser, s0.tlast, s0.tdata};
      fd_exp = 1'b0;
      if (s0.tvalid && s0.tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", {s0.tuser, s0.tlast, 6'd0, s0.tdata}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 32'(s0.tdata), 32'(e[23:0]));
          chk("tuser", 32'(s0.tuser), 32'(e[25]));
          chk("tlast", 32'(s0.tlast), 32'(e[24]));
          fd_exp = e[26];
          if (e[25]) begin
            if (chk_bubble && last_fr_valid) chk("sof_bubble", 32'(cyc - last_fr_cyc), 3);
          end
          if (e[26]) begin
            last_fr_cyc   = cyc;
            last_fr_valid = 1'b1;
          end
        end
        if (s0.tuser) tuser_cnt++;
        beats++;
      end
    end else begin
      fd_exp   = 1'b0;
      hold_chk = 1'b0;
    end
  end

  initial begin
    int n, b0, t0, tv, fdc, nb, tlast_cyc, gap;
    logic seen_last, gap_done;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // back-to-back 4x2 frames, tready held high
    width = 16'd4; height = 16'd2;
    chk_bubble = 1'b1;
    push_frame(4, 2);
    push_frame(4, 2);
    b0 = beats;
    enable = 1'b1;
    n = 0;
    while (!s0.tvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("first_beat_latency", 32'(n), 3);
    while (beats < b0 + 9 && n < 60) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    wait_done("burst", 60);
    chk("burst_beats", 32'(beats - b0), 16);
    chk("burst_tuser", 32'(tuser_cnt), 2);
    chk_bubble = 1'b0;

    // same geometry under random backpressure
    rand_rdy = 1'b1;
    push_frame(4, 2);
    b0 = beats;
    enable = 1'b1;
    @(negedge clk);
    chk("busy_after_enable", 32'(busy0), 1);
    enable = 1'b0;
    wait_done("stall", 300);
    chk("stall_beats", 32'(beats - b0), 8);
    rand_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // 3x3, enable dropped after the third beat
    width = 16'd3; height = 16'd3;
    push_frame(3, 3);
    b0 = beats;
    t0 = tuser_cnt;
    enable = 1'b1;
    n = 0;
    while (beats < b0 + 3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    wait_done("drop_en", 60);
    repeat (10) @(negedge clk);
    chk("drop_en_beats", 32'(beats - b0), 9);
    chk("drop_en_tuser", 32'(tuser_cnt - t0), 1);
    chk("drop_en_busy", 32'(busy0), 0);

    // zero geometry: IDLE<->LOAD only
    for (int k = 0; k < 2; k++) begin
      width  = (k == 0) ? 16'd0 : 16'd3;
      height = (k == 0) ? 16'd2 : 16'd0;
      tv = 0; fdc = 0; nb = 0;
      enable = 1'b1;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (s0.tvalid) tv++;
        if (fd0) fdc++;
        if (busy0) nb++;
      end
      enable = 1'b0;
      chk("zero_tvalid", 32'(tv), 0);
      chk("zero_fd", 32'(fdc), 0);
      chk("zero_load_cycles", 32'(nb), 8);
      repeat (3) @(negedge clk);
    end

    // GAP_CYCLES=5 instance, 2x1 frames
    width = 16'd2; height = 16'd1;
    enable5 = 1'b1;
    seen_last = 1'b0; gap_done = 1'b0; tlast_cyc = 0; gap = 0;
    for (int i = 0; i < 60 && !gap_done; i++) begin
      @(negedge clk);
      if (pix_req5 && x5 == 16'd1) begin
        tlast_cyc = cyc;
        seen_last = 1'b1;
      end else if (pix_req5 && x5 == 16'd0 && y5 == 16'd0 && seen_last) begin
        gap = cyc - tlast_cyc;
        gap_done = 1'b1;
      end
    end
    enable5 = 1'b0;
    chk("gap_seen", 32'(gap_done), 1);
    chk("gap_cycles", 32'(gap), 8);
    repeat (12) @(negedge clk);
    chk("gap_idle", 32'(busy5), 0);

    // reset in the middle of a 4x2 frame
    width = 16'd4; height = 16'd2;
    push_frame(4, 2);
    b0 = beats;
    enable = 1'b1;
    n = 0;
    while (beats < b0 + 6 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_beats", 32'(beats - b0), 6);
    rst = 1'b1;
    mon_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_reset_vals("midreset");
    push_frame(4, 2);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    wait_done("post_reset", 60);
    chk("post_reset_frame_done_seen", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/video_frame_gen.md
# video_frame_gen

Source-side AXI4-Stream video frame generator for the wave_former pipeline. It walks a raster of programmable width × height. It presents the current pixel coordinate to a combinational pixel source and registers the returned pixel onto a stream master, with tuser marking start-of-frame and tlast marking end-of-line. It sits upstream of every sink that reconstructs x/y from the tuser/tlast convention, and must produce exactly the framing those sinks expect.

## Interface

- DATA_W, 24: pixel width in bits.
- GAP_CYCLES, 0: idle cycles inserted after the last pixel of a frame is captured (0..65535).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  run request; sampled in IDLE and at frame boundaries.
- width  in  16  active pixels per line; latched in LOAD.
- height  in  16  lines per frame; latched in LOAD.
- x  out  16  column of the pixel being requested this cycle.
- y  out  16  line of the pixel being requested this cycle.
- pix_req  out  1  high when pix_data is captured this cycle.
- pix_data  in  DATA_W  pixel for (x, y); combinational from x/y, valid in the same cycle.
- m_tdata  out  DATA_W  stream pixel.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tuser  out  1  start-of-frame; high on pixel (0,0) only.
- m_tlast  out  1  end-of-line; high on x == width-1.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse when the last beat of a frame is accepted.

## Operation

- States:
  - IDLE: enable=1 → LOAD.
  - LOAD: one cycle.
    - Latch w_r = width and h_r = height; clear x and y.
    - If width==0 or height==0 → IDLE, no beats emitted.
    - Otherwise → RUN.
  - RUN: emit pixels.
    - After capturing pixel (w_r-1, h_r-1): GAP_CYCLES>0 → GAP, else IDLE.
  - GAP: count GAP_CYCLES cycles, then → IDLE.
  - The IDLE→LOAD path makes frames continue back-to-back while enable=1.
- Output register: a single stage holding tdata/tuser/tlast, with m_tvalid as its full flag.
- Capture condition: cap = (state==RUN) & (~m_tvalid | m_tready). pix_req = cap.
- On cap:
  - m_tdata ← pix_data.
  - m_tuser ← (x==0 & y==0).
  - m_tlast ← (x==w_r-1).
  - m_tvalid ← 1.
  - Advance counters: x==w_r-1 → x←0, y←y+1; else x←x+1.
- When m_tready & m_tvalid & ~cap: m_tvalid ← 0.
- AXI rule: while m_tvalid=1 & m_tready=0, tdata/tuser/tlast/tvalid are held stable.
- enable deassert in RUN: the current frame completes; it is not truncated. enable is ignored until the frame ends.
- width/height changes during a frame have no effect until the next LOAD.
- frame_done: asserted on the handshake of the beat with tlast=1 and y==h_r-1 (tracked by a registered last-of-frame flag alongside the output register).
- Counters are 16-bit unsigned; x < w_r and y < h_r always hold, so no wrap is possible.
- Reset mid-frame: every register clears on the next edge. m_tvalid drops without a handshake; downstream re-syncs on the next tuser.

## Timing

- Reset values:
  - state=IDLE.
  - x=0, y=0.
  - m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0.
  - pix_req=0, busy=0, frame_done=0.
- Latency:
  - enable rising in IDLE → LOAD next cycle → first capture in the following cycle → m_tvalid high one cycle after that (3 edges).
  - Pixel source → m_tdata: 1 cycle.
- Throughput: 1 pixel/cycle with m_tready=1.
- Frame-to-frame bubble: 2 cycles (IDLE + LOAD) + GAP_CYCLES.
- frame_done is registered: high the cycle after the final handshake edge, for exactly one cycle.

## Structure

- Package wave_former_pkg:
  - typedef coord_t (logic [15:0]).
  - enum gen_state_e {IDLE, LOAD, RUN, GAP}.
  - constant COORD_W=16.
- One natural sub-module: raster_counter. It holds x/y, the w_r/h_r latches, and the last-pixel/last-line flags, with step and clear inputs. The FSM and output register stay in the top.

## Test plan

- width=4, height=2, GAP_CYCLES=0, tready=1, enable held:
  - 8 beats per frame.
  - tuser on beat 0 only; tlast on beats 3 and 7.
  - frame_done one cycle after beat 7.
  - Next frame's tuser arrives after a 2-cycle bubble.
- Same geometry with tready toggling 1,0,0,1,… (random):
  - Data = {y,x} pattern from the source.
  - Beat order and values are identical to the tready=1 run.
  - Outputs are stable during every stall.
- width=3, height=3, enable dropped after beat 2:
  - All 9 beats emitted, then IDLE, busy=0.
  - No further tuser.
- width=0 or height=0 with enable=1:
  - FSM cycles IDLE↔LOAD.
  - m_tvalid never rises; frame_done never pulses.
- GAP_CYCLES=5, width=2, height=1:
  - Gap between the tlast beat's capture and the next tuser capture is 5+2 cycles.
- rst asserted mid-frame (beat 5 of 4×2):
  - All outputs at reset values next cycle.
  - After release with enable=1, the first beat carries tuser, x=0, y=0.
